// File: rtl/chip_pkg.sv
// chip_pkg: shared Chip widths, derived sizes and the burst driver state type.
package chip_pkg;
    localparam int BGWIDTH       = 2;
    localparam int BAWIDTH       = 2;
    localparam int COLWIDTH      = 10;
    localparam int DEVICE_WIDTH  = 4;
    localparam int BL            = 8;
    localparam int CHWIDTH       = 5;
    localparam int BANKGROUPS    = 2 ** BGWIDTH;
    localparam int BANKSPERGROUP = 2 ** BAWIDTH;
    localparam int COLS          = 2 ** COLWIDTH;
    localparam int BEATW         = $clog2(BL);
    typedef enum logic [2:0] {IDLE, WBURST, RBURST, DRAIN, RESP} drv_state_t;
endpackage

// File: rtl/chip_burst_driver_if.sv
// chip_burst_driver_if: burst request/response handshake plus the per-bank Chip array.
interface chip_burst_driver_if;
    import chip_pkg::*;
    logic                       req_valid;
    logic                       req_ready;
    logic                       req_write;
    logic [BGWIDTH-1:0]         req_bg;
    logic [BAWIDTH-1:0]         req_ba;
    logic [CHWIDTH-1:0]         req_row;
    logic [COLWIDTH-1:0]        req_col;
    logic [BL*DEVICE_WIDTH-1:0] req_wdata;
    logic                       rsp_valid;
    logic                       rsp_write;
    logic [BL*DEVICE_WIDTH-1:0] rsp_rdata;
    logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0]                   rd_o_wr;
    logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][DEVICE_WIDTH-1:0] dqin;
    logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][CHWIDTH-1:0]      row;
    logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][COLWIDTH-1:0]     column;
    logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][DEVICE_WIDTH-1:0] dqout;

    modport master (
        input  req_valid, req_write, req_bg, req_ba, req_row, req_col, req_wdata, dqout,
        output req_ready, rsp_valid, rsp_write, rsp_rdata, rd_o_wr, dqin, row, column
    );
    modport slave (
        output req_valid, req_write, req_bg, req_ba, req_row, req_col, req_wdata, dqout,
        input  req_ready, rsp_valid, rsp_write, rsp_rdata, rd_o_wr, dqin, row, column
    );
endinterface

// File: rtl/burst_rd_capture.sv
// burst_rd_capture: delays read beat indices by RDLAT cycles and drops the
// returning dq into the matching rsp_rdata slot.
module burst_rd_capture
    import chip_pkg::*;
#(
    parameter int RDLAT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       issue,
    input  logic [BEATW-1:0]           idx,
    input  logic [DEVICE_WIDTH-1:0]    dq,
    output logic [BL*DEVICE_WIDTH-1:0] rdata
);
    logic [RDLAT-1:0]            vld;
    logic [RDLAT-1:0][BEATW-1:0] pidx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld   <= '0;
            pidx  <= '0;
            rdata <= '0;
        end else begin
            vld[0]  <= issue;
            pidx[0] <= idx;
            for (int i = 1; i < RDLAT; i++) begin
                vld[i]  <= vld[i-1];
                pidx[i] <= pidx[i-1];
            end
            if (clear)
                rdata <= '0;
            else if (vld[RDLAT-1])
                rdata[pidx[RDLAT-1]*DEVICE_WIDTH +: DEVICE_WIDTH] <= dq;
        end
    end
endmodule

// File: rtl/chip_burst_driver.sv
// chip_burst_driver: expands one burst request into BL per-beat accesses on the
// per-bank Chip array and gathers read beats into a single response.
module chip_burst_driver
    import chip_pkg::*;
#(
    parameter int RDLAT = 1
) (
    input logic                 clk,
    input logic                 rst,
    chip_burst_driver_if.master bus
);
    localparam logic [1:0] LAT_END = 2'(RDLAT - 1);

    drv_state_t                 state, nxt;
    logic [BEATW-1:0]           beat;
    logic [1:0]                 lat;
    logic                       wr_q;
    logic [BGWIDTH-1:0]         bg_q;
    logic [BAWIDTH-1:0]         ba_q;
    logic [CHWIDTH-1:0]         row_q;
    logic [COLWIDTH-1:0]        col_q;
    logic [BL*DEVICE_WIDTH-1:0] wdata_q;
    logic                       accept, bursting, last_beat;

    assign accept    = state == IDLE && bus.req_valid;
    assign bursting  = state == WBURST || state == RBURST;
    assign last_beat = beat == BEATW'(BL - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            beat    <= '0;
            lat     <= '0;
            wr_q    <= 1'b0;
            bg_q    <= '0;
            ba_q    <= '0;
            row_q   <= '0;
            col_q   <= '0;
            wdata_q <= '0;
        end else begin
            state <= nxt;
            beat  <= bursting && !last_beat ? beat + 1'b1 : '0;
            lat   <= state == DRAIN ? lat + 1'b1 : '0;
            if (accept) begin
                wr_q    <= bus.req_write;
                bg_q    <= bus.req_bg;
                ba_q    <= bus.req_ba;
                row_q   <= bus.req_row;
                col_q   <= bus.req_col;
                wdata_q <= bus.req_wdata;
            end
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (bus.req_valid) nxt = bus.req_write ? WBURST : RBURST;
            WBURST:  if (last_beat) nxt = RESP;
            RBURST:  if (last_beat) nxt = DRAIN;
            DRAIN:   if (lat == LAT_END) nxt = RESP;
            RESP:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Only the latched bank is ever driven; the column wraps within COLWIDTH bits.
    always_comb begin
        bus.rd_o_wr = '0;
        bus.dqin    = '0;
        bus.row     = '0;
        bus.column  = '0;
        if (bursting) begin
            bus.rd_o_wr[bg_q][ba_q] = state == WBURST;
            bus.row[bg_q][ba_q]     = row_q;
            bus.column[bg_q][ba_q]  = col_q + COLWIDTH'(beat);
            bus.dqin[bg_q][ba_q]    = state == WBURST ? wdata_q[beat*DEVICE_WIDTH +: DEVICE_WIDTH] : '0;
        end
    end

    assign bus.req_ready = state == IDLE;
    assign bus.rsp_valid = state == RESP;
    assign bus.rsp_write = state == RESP && wr_q;

    burst_rd_capture #(.RDLAT(RDLAT)) u_cap (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .issue (state == RBURST),
        .idx   (beat),
        .dq    (bus.dqout[bg_q][ba_q]),
        .rdata (bus.rsp_rdata)
    );
endmodule
